tlb_lru_ctrl: RTL and testbench
===============================

# tlb_lru_ctrl

TLB refill and LRU controller for the 4-way set-associative TLB. Owns per-set LRU counters and sequences each TLB miss: picks the victim way from the counters, issues a page-walk request, and writes the returned translation into the victim way. Also applies LRU updates on TLB hits. Sits between the TLB lookup pipeline, the page-table walker and the TLB entry array.

## Interface
- `NUM_WAYS`, 4: ways per set. Fixed at 4; the way fields are 2 bits wide.
- `LRU_BITS`, 4: width of each LRU counter.
- `NUM_SETS`, 16: number of TLB sets.
- `SET_BITS`, 4: log2(`NUM_SETS`).
- `VPN_BITS`, 20: virtual page number width.
- `PPN_BITS`, 20: physical page number width.

One clock. Reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `hit_valid` in 1: TLB hit this cycle; apply an LRU update.
- `hit_set` in `SET_BITS`: set of the hit.
- `hit_way` in 2: way of the hit.
- `miss_valid` in 1: miss request.
- `miss_ready` out 1: controller can accept a miss.
- `miss_set` in `SET_BITS`: set of the missing VPN.
- `miss_vpn` in `VPN_BITS`: the missing VPN.
- `walk_req_valid` out 1: page-walk request.
- `walk_req_ready` in 1: walker accepts the request.
- `walk_req_vpn` out `VPN_BITS`: VPN to walk.
- `walk_resp_valid` in 1: walk result valid; single-cycle pulse.
- `walk_resp_ppn` in `PPN_BITS`: translated PPN.
- `walk_resp_fault` in 1: the walk faulted.
- `fill_valid` out 1: write the entry array this cycle.
- `fill_set` out `SET_BITS`: set to write.
- `fill_way` out 2: way to write.
- `fill_vpn` out `VPN_BITS`: VPN to write.
- `fill_ppn` out `PPN_BITS`: PPN to write.
- `refill_done` out 1: one-cycle pulse when a fill completes.
- `refill_fault` out 1: one-cycle pulse when a walk faulted.
- `busy` out 1: the state is not IDLE.

## Operation
- Storage: counter array `cnt[set][way]` of `LRU_BITS` bits.
- Victim selection: lowest-index way holding the minimum counter in the set.
- Max: maximum counter in the set.
- LRU update of way `w` in set `s`, evaluated on the current values:
  - if max < 15: `cnt[s][w]` = max+1;
  - if max == 15: every other way in set `s` shifts right by 1, and `cnt[s][w]` = 8.
- FSM states and transitions:
  - IDLE: `miss_ready`=1. On `miss_valid`, latch set and VPN, go to SELECT.
  - SELECT: latch the victim way from the registered counters, go to WALK_REQ.
  - WALK_REQ: `walk_req_valid`=1 and `walk_req_vpn`=latched VPN, held stable until `walk_req_ready`, then go to WALK_WAIT.
  - WALK_WAIT: on `walk_resp_valid` with fault, pulse `refill_fault` and go to IDLE. Otherwise latch the PPN and go to FILL.
  - FILL: `fill_valid`=1 and `refill_done`=1 with the latched set, way, VPN and PPN. Apply the LRU update to the victim, then go to IDLE.
- `walk_resp_valid` is ignored outside WALK_WAIT.
- A fault performs no fill and no LRU update.
- Hits are accepted in every state. A hit during a refill does not change the already-latched victim.
- Hit and FILL update in the same cycle:
  - different sets: both updates apply;
  - same set: the fill update wins and the hit is dropped.
- A hit in the same cycle as SELECT: SELECT uses the pre-update counters.

## Timing
- Reset values:
  - state IDLE, all counters 0;
  - `walk_req_valid`, `fill_valid`, `refill_done`, `refill_fault`, `busy` = 0;
  - fill and walk data outputs = 0;
  - `miss_ready` = 1.
- Miss accepted at edge T:
  - SELECT in cycle T+1;
  - `walk_req_valid` rises in cycle T+2.
- Walk request accepted at edge A: WALK_WAIT from A+1.
- Response accepted at edge R:
  - `fill_valid` and `refill_done` in cycle R+1;
  - counter update visible from R+2;
  - `miss_ready` high again in R+2.
- Fault at edge R: `refill_fault` high in R+1, with `miss_ready`=1 in R+1.
- Minimum miss-to-fill: 4 cycles (accept T, fill T+4).
- Hit update visible the cycle after `hit_valid`.
- Reset mid-refill: immediately returns to IDLE and clears the counters. No fill occurs for the aborted miss, and a late walk response is ignored.

## Test plan
- Reset, then miss set 3 / VPN 0x12345 with `walk_req_ready`=1 and the response PPN 0xABCDE one cycle later -> `fill_valid` at T+4 with way 0 and PPN 0xABCDE; set 3 counters become [1,0,0,0].
- Three more set-3 misses -> fills to ways 1, 2, 3, counters [1,2,3,4]. Hit way 0 -> [5,2,3,4]. Next miss -> `fill_way`=1.
- Saturation: fifteen hits to set 0 way 0 from reset -> [15,0,0,0]. Hit way 1 -> [7,8,0,0].
- Fault response -> `refill_fault` pulses 1 cycle; no `fill_valid`; counters unchanged; `miss_ready`=1 in R+1.
- `walk_req_ready` held low 5 cycles -> `walk_req_valid` and VPN stable throughout. A set-5 hit during this window updates set 5.
- Same-set hit in the FILL cycle -> only the fill update appears. `rst_n` low during WALK_WAIT -> IDLE, counters 0, a later response produces no fill.

Source files
------------

// File: rtl/tlb_lru_ctrl_if.sv
// Handshake bundle between the TLB lookup pipe, the page-table walker
// and the refill/LRU controller.
interface tlb_lru_ctrl_if #(
   parameter int SET_BITS = 4,
   parameter int VPN_BITS = 20,
   parameter int PPN_BITS = 20
);
   logic                hit_valid;
   logic [SET_BITS-1:0] hit_set;
   logic [1:0]          hit_way;
   logic                miss_valid;
   logic                miss_ready;
   logic [SET_BITS-1:0] miss_set;
   logic [VPN_BITS-1:0] miss_vpn;
   logic                walk_req_valid;
   logic                walk_req_ready;
   logic [VPN_BITS-1:0] walk_req_vpn;
   logic                walk_resp_valid;
   logic [PPN_BITS-1:0] walk_resp_ppn;
   logic                walk_resp_fault;
   logic                fill_valid;
   logic [SET_BITS-1:0] fill_set;
   logic [1:0]          fill_way;
   logic [VPN_BITS-1:0] fill_vpn;
   logic [PPN_BITS-1:0] fill_ppn;
   logic                refill_done;
   logic                refill_fault;
   logic                busy;

   modport master (
      output hit_valid, hit_set, hit_way,
      output miss_valid, miss_set, miss_vpn,
      output walk_req_ready,
      output walk_resp_valid, walk_resp_ppn, walk_resp_fault,
      input  miss_ready, walk_req_valid, walk_req_vpn,
      input  fill_valid, fill_set, fill_way, fill_vpn, fill_ppn,
      input  refill_done, refill_fault, busy
   );

   modport slave (
      input  hit_valid, hit_set, hit_way,
      input  miss_valid, miss_set, miss_vpn,
      input  walk_req_ready,
      input  walk_resp_valid, walk_resp_ppn, walk_resp_fault,
      output miss_ready, walk_req_valid, walk_req_vpn,
      output fill_valid, fill_set, fill_way, fill_vpn, fill_ppn,
      output refill_done, refill_fault, busy
   );
endinterface

// File: rtl/tlb_lru_ctrl.sv
// TLB refill sequencer with per-set LRU counters for a 4-way TLB:
// victim pick, page-walk request, fill of the victim way, hit updates.
module tlb_lru_ctrl #(
   parameter int NUM_WAYS = 4,
   parameter int LRU_BITS = 4,
   parameter int NUM_SETS = 16,
   parameter int SET_BITS = 4,
   parameter int VPN_BITS = 20,
   parameter int PPN_BITS = 20
) (
   input logic           clk,
   input logic           rst_n,
   tlb_lru_ctrl_if.slave bus
);
   localparam int ROW = NUM_WAYS * LRU_BITS;

   typedef enum logic [2:0] {
      IDLE, SELECT, WALK_REQ, WALK_WAIT, FILL
   } state_t;

   state_t state;

   logic [NUM_SETS-1:0][ROW-1:0] cnt;

   logic [SET_BITS-1:0] lat_set;
   logic [VPN_BITS-1:0] lat_vpn;
   logic [PPN_BITS-1:0] lat_ppn;
   logic [1:0]          lat_way;
   logic                miss_ready_q;
   logic                busy_q;
   logic                req_valid_q;
   logic                fill_q;
   logic                fault_q;

   function automatic logic [ROW-1:0] lru_upd(
      input logic [ROW-1:0] row,
      input logic [1:0]     w
   );
      logic [LRU_BITS-1:0] mx;
      logic [ROW-1:0]      r;
      mx = '0;
      for (int i = 0; i < NUM_WAYS; i++)
         if (row[i*LRU_BITS +: LRU_BITS] > mx)
            mx = row[i*LRU_BITS +: LRU_BITS];
      r = row;
      if (mx != '1) begin
         r[int'(w)*LRU_BITS +: LRU_BITS] = mx + 1'b1;
      end else begin
         // saturated set: age the others, restart the touched way at half range
         for (int i = 0; i < NUM_WAYS; i++)
            r[i*LRU_BITS +: LRU_BITS] = row[i*LRU_BITS +: LRU_BITS] >> 1;
         r[int'(w)*LRU_BITS +: LRU_BITS] = {1'b1, {(LRU_BITS-1){1'b0}}};
      end
      return r;
   endfunction

   function automatic logic [1:0] victim(input logic [ROW-1:0] row);
      logic [LRU_BITS-1:0] mn;
      logic [1:0]          v;
      mn = row[LRU_BITS-1:0];
      v  = '0;
      for (int i = 1; i < NUM_WAYS; i++)
         if (row[i*LRU_BITS +: LRU_BITS] < mn) begin
            mn = row[i*LRU_BITS +: LRU_BITS];
            v  = 2'(i);
         end
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         lat_set      <= '0;
         lat_vpn      <= '0;
         lat_ppn      <= '0;
         lat_way      <= '0;
         miss_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         fill_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         fill_q  <= 1'b0;
         fault_q <= 1'b0;
         unique case (state)
            IDLE: if (bus.miss_valid) begin
               lat_set      <= bus.miss_set;
               lat_vpn      <= bus.miss_vpn;
               miss_ready_q <= 1'b0;
               busy_q       <= 1'b1;
               state        <= SELECT;
            end
            SELECT: begin
               lat_way     <= victim(cnt[lat_set]);
               req_valid_q <= 1'b1;
               state       <= WALK_REQ;
            end
            WALK_REQ: if (bus.walk_req_ready) begin
               req_valid_q <= 1'b0;
               state       <= WALK_WAIT;
            end
            WALK_WAIT: if (bus.walk_resp_valid) begin
               if (bus.walk_resp_fault) begin
                  fault_q      <= 1'b1;
                  miss_ready_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state        <= IDLE;
               end else begin
                  lat_ppn <= bus.walk_resp_ppn;
                  fill_q  <= 1'b1;
                  state   <= FILL;
               end
            end
            FILL: begin
               miss_ready_q <= 1'b1;
               busy_q       <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // a same-set hit in the fill cycle is dropped in favour of the fill
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         if (state == FILL)
            cnt[lat_set] <= lru_upd(cnt[lat_set], lat_way);
         if (bus.hit_valid &&
             !(state == FILL && bus.hit_set == lat_set))
            cnt[bus.hit_set] <= lru_upd(cnt[bus.hit_set], bus.hit_way);
      end
   end

   assign bus.miss_ready     = miss_ready_q;
   assign bus.busy           = busy_q;
   assign bus.walk_req_valid = req_valid_q;
   assign bus.walk_req_vpn   = lat_vpn;
   assign bus.fill_valid     = fill_q;
   assign bus.refill_done    = fill_q;
   assign bus.refill_fault   = fault_q;
   assign bus.fill_set       = lat_set;
   assign bus.fill_way       = lat_way;
   assign bus.fill_vpn       = lat_vpn;
   assign bus.fill_ppn       = lat_ppn;
endmodule

// File: tb/tb_tlb_lru_ctrl.sv
// Bench for tlb_lru_ctrl: directed refill sequences, a hit table,
// and random traffic against a transaction-level reference model.
module tb_tlb_lru_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tlb_lru_ctrl_if bus ();
   tlb_lru_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int failures = 0;
   int m [16][4];

   typedef struct {
      int         set;
      int         way;
      int         reps;
      logic [15:0] exp;
   } hit_vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] pk(input int a, b, c, d);
      return {4'(d), 4'(c), 4'(b), 4'(a)};
   endfunction

   task automatic chk_set(input int s, input logic [15:0] e);
      chk($sformatf("cnt_set%0d", s), 32'(dut.cnt[s]), 32'(e));
   endtask

   task automatic quiet();
      bus.hit_valid = 0; bus.hit_set = 0; bus.hit_way = 0;
      bus.miss_valid = 0; bus.miss_set = 0; bus.miss_vpn = 0;
      bus.walk_req_ready = 0; bus.walk_resp_valid = 0;
      bus.walk_resp_ppn = 0; bus.walk_resp_fault = 0;
   endtask

   task automatic do_hit(input int s, input int w);
      bus.hit_valid = 1; bus.hit_set = 4'(s); bus.hit_way = 2'(w);
      tick();
      bus.hit_valid = 0;
   endtask

   task automatic refill(
      input int s, input logic [19:0] v, input logic [19:0] p,
      input logic flt, input int ew, input int hold,
      input logic hh, input int hhs, input int hhw,
      input logic fh, input int fhs, input int fhw
   );
      chk("ready_idle", bus.miss_ready, 1);
      bus.miss_valid = 1; bus.miss_set = 4'(s); bus.miss_vpn = v;
      tick();
      bus.miss_valid = 0; bus.miss_vpn = ~v;
      chk("sel_busy", bus.busy, 1);
      chk("sel_ready", bus.miss_ready, 0);
      chk("sel_req", bus.walk_req_valid, 0);
      tick();
      for (int i = 0; i < hold; i++) begin
         chk("hold_req", bus.walk_req_valid, 1);
         chk("hold_vpn", bus.walk_req_vpn, v);
         if (hh && i == 0) begin
            bus.hit_valid = 1; bus.hit_set = 4'(hhs); bus.hit_way = 2'(hhw);
         end
         tick();
         bus.hit_valid = 0;
      end
      chk("req_valid", bus.walk_req_valid, 1);
      chk("req_vpn", bus.walk_req_vpn, v);
      bus.walk_req_ready = 1;
      tick();
      bus.walk_req_ready = 0;
      chk("req_drop", bus.walk_req_valid, 0);
      bus.walk_resp_valid = 1; bus.walk_resp_ppn = p;
      bus.walk_resp_fault = flt;
      tick();
      bus.walk_resp_valid = 0; bus.walk_resp_fault = 0;
      if (flt) begin
         chk("fault_pulse", bus.refill_fault, 1);
         chk("fault_nofill", bus.fill_valid, 0);
         chk("fault_ready", bus.miss_ready, 1);
         tick();
         chk("fault_end", bus.refill_fault, 0);
      end else begin
         chk("fill_valid", bus.fill_valid, 1);
         chk("fill_done", bus.refill_done, 1);
         chk("fill_set", bus.fill_set, 32'(s));
         chk("fill_way", bus.fill_way, 32'(ew));
         chk("fill_vpn", bus.fill_vpn, v);
         chk("fill_ppn", bus.fill_ppn, p);
         chk("fill_ready", bus.miss_ready, 0);
         if (fh) begin
            bus.hit_valid = 1; bus.hit_set = 4'(fhs); bus.hit_way = 2'(fhw);
         end
         tick();
         bus.hit_valid = 0;
         chk("fill_end", bus.fill_valid, 0);
         chk("done_end", bus.refill_done, 0);
         chk("ready_back", bus.miss_ready, 1);
      end
   endtask

   function automatic void m_upd(input int s, input int w);
      int mx;
      mx = 0;
      foreach (m[s][i]) if (m[s][i] > mx) mx = m[s][i];
      if (mx < 15) begin
         m[s][w] = mx + 1;
      end else begin
         foreach (m[s][i]) if (i != w) m[s][i] = m[s][i] / 2;
         m[s][w] = 8;
      end
   endfunction

   function automatic int m_victim(input int s);
      int v;
      v = 0;
      for (int i = 1; i < 4; i++) if (m[s][i] < m[s][v]) v = i;
      return v;
   endfunction

   hit_vec_t tbl [7];

   initial begin
      bit act, rdone, fnext, fltnext, nfill, nflt, exp_req;
      int age, ts, tw;
      logic [19:0] tv, tp;
      bit hv, mv, wr, rv, flt;
      int hs, hw, ms;
      logic [19:0] mvpn, ppn;

      tbl[0] = '{0, 0, 15, pk(15, 0, 0, 0)};
      tbl[1] = '{0, 1, 1, pk(7, 8, 0, 0)};
      tbl[2] = '{0, 2, 1, pk(7, 8, 9, 0)};
      tbl[3] = '{0, 2, 1, pk(7, 8, 10, 0)};
      tbl[4] = '{6, 3, 1, pk(0, 0, 0, 1)};
      tbl[5] = '{6, 3, 1, pk(0, 0, 0, 2)};
      tbl[6] = '{6, 0, 1, pk(3, 0, 0, 2)};

      quiet();
      rst_n = 0;
      tick();
      chk("rst_ready", bus.miss_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_req", bus.walk_req_valid, 0);
      chk("rst_fill", bus.fill_valid, 0);
      chk("rst_done", bus.refill_done, 0);
      chk("rst_fault", bus.refill_fault, 0);
      chk("rst_ppn", bus.fill_ppn, 0);
      chk("rst_vpn", bus.walk_req_vpn, 0);
      rst_n = 1;
      tick();
      chk_set(3, pk(0, 0, 0, 0));

      refill(3, 20'h12345, 20'hABCDE, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_set(3, pk(1, 0, 0, 0));
      refill(3, 20'h11111, 20'h22222, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      refill(3, 20'h33333, 20'h44444, 0, 2, 0, 0, 0, 0, 0, 0, 0);
      refill(3, 20'h55555, 20'h66666, 0, 3, 0, 0, 0, 0, 0, 0, 0);
      chk_set(3, pk(1, 2, 3, 4));
      do_hit(3, 0);
      chk_set(3, pk(5, 2, 3, 4));
      refill(3, 20'h77777, 20'h88888, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk_set(3, pk(5, 6, 3, 4));
      refill(3, 20'h99999, 20'hAAAAA, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk_set(3, pk(5, 6, 3, 4));
      refill(7, 20'hBBBBB, 20'hCCCCC, 0, 0, 5, 1, 5, 2, 0, 0, 0);
      chk_set(5, pk(0, 0, 1, 0));
      chk_set(7, pk(1, 0, 0, 0));
      refill(3, 20'hDDDDD, 20'hEEEEE, 0, 2, 0, 0, 0, 0, 1, 3, 0);
      chk_set(3, pk(5, 6, 7, 4));
      refill(3, 20'h0F0F0, 20'h1E1E1, 0, 3, 0, 0, 0, 0, 1, 9, 1);
      chk_set(3, pk(5, 6, 7, 8));
      chk_set(9, pk(0, 1, 0, 0));

      // reset while waiting for the walker
      bus.miss_valid = 1; bus.miss_set = 2; bus.miss_vpn = 20'h2468A;
      tick();
      bus.miss_valid = 0;
      tick();
      bus.walk_req_ready = 1;
      tick();
      bus.walk_req_ready = 0;
      chk("ww_busy", bus.busy, 1);
      rst_n = 0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_ready", bus.miss_ready, 1);
      chk_set(3, pk(0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1;
      bus.walk_resp_valid = 1; bus.walk_resp_ppn = 20'h13579;
      tick();
      bus.walk_resp_valid = 0;
      chk("late_nofill", bus.fill_valid, 0);
      chk("late_busy", bus.busy, 0);
      tick();
      chk("late_nofill2", bus.fill_valid, 0);

      foreach (tbl[k]) begin
         for (int r = 0; r < tbl[k].reps; r++) do_hit(tbl[k].set, tbl[k].way);
         chk_set(tbl[k].set, tbl[k].exp);
      end

      rst_n = 0;
      tick();
      rst_n = 1;
      foreach (m[i, j]) m[i][j] = 0;
      act = 0; rdone = 0; fnext = 0; fltnext = 0; age = 0;
      ts = 0; tw = 0; tv = 0; tp = 0;
      for (int c = 0; c < 3000; c++) begin
         exp_req = act && age >= 1 && !rdone && !fnext;
         chk("r_ready", bus.miss_ready, !act);
         chk("r_busy", bus.busy, act);
         chk("r_req", bus.walk_req_valid, exp_req);
         if (exp_req) chk("r_vpn", bus.walk_req_vpn, tv);
         chk("r_fill", bus.fill_valid, fnext);
         chk("r_done", bus.refill_done, fnext);
         chk("r_fault", bus.refill_fault, fltnext);
         if (fnext) begin
            chk("r_fset", bus.fill_set, 32'(ts));
            chk("r_fway", bus.fill_way, 32'(tw));
            chk("r_fvpn", bus.fill_vpn, tv);
            chk("r_fppn", bus.fill_ppn, tp);
         end
         for (int s = 0; s < 4; s++)
            chk_set(s, pk(m[s][0], m[s][1], m[s][2], m[s][3]));

         hv = ($urandom % 2) == 0; hs = $urandom % 4; hw = $urandom % 4;
         mv = ($urandom % 2) == 0; ms = $urandom % 4;
         mvpn = 20'($urandom);
         wr = ($urandom % 2) == 0;
         rv = ($urandom % 3) == 0;
         flt = ($urandom % 4) == 0;
         ppn = 20'($urandom);
         bus.hit_valid = hv; bus.hit_set = 4'(hs); bus.hit_way = 2'(hw);
         bus.miss_valid = mv; bus.miss_set = 4'(ms); bus.miss_vpn = mvpn;
         bus.walk_req_ready = wr; bus.walk_resp_valid = rv;
         bus.walk_resp_fault = flt; bus.walk_resp_ppn = ppn;

         nfill = 0; nflt = 0;
         if (act && !fnext && age == 0) tw = m_victim(ts);
         if (hv && !(fnext && hs == ts)) m_upd(hs, hw);
         if (fnext) begin
            m_upd(ts, tw);
            act = 0;
         end else if (act) begin
            if (age >= 1 && !rdone) begin
               if (wr) rdone = 1;
            end else if (rdone && rv) begin
               if (flt) begin
                  act = 0; nflt = 1;
               end else begin
                  tp = ppn; nfill = 1;
               end
            end
            age++;
         end else if (mv) begin
            act = 1; age = 0; rdone = 0; ts = ms; tv = mvpn;
         end
         fnext = nfill; fltnext = nflt;
         tick();
      end
      quiet();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
